// File: rtl/global_buffer_dp_if.sv
// Bus bundle for global_buffer_dp: clear control, write port and read port.
//   master: host/DMA loader + operand fetch side (drives requests)
//   slave : buffer side (drives busy, read data/strobes, address error)
// Parameters: DATA_W (word width, multiple of 8), ADDR_W (address width).
interface global_buffer_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                  clr_req;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  addr_err;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, rd_data, rd_valid, addr_err
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, rd_data, rd_valid, addr_err
    );
endinterface

// File: rtl/global_buffer_dp.sv
// Simple-dual-port global buffer (one write, one read per cycle) between the
// host/DMA loader and the PE-array operand fetch.
//   clk    : clock, all logic on posedge
//   rst_n  : asynchronous active-low reset; starts a full clear sweep
//   bus    : global_buffer_dp_if.slave
//            clr_req            start a clear sweep (only from IDLE)
//            busy               high while the sweep runs; requests ignored
//            wr_en/addr/data/be byte-enabled write
//            rd_en/addr         read request, rd_data/rd_valid one cycle later
//            addr_err           strobe one cycle after an out-of-range access
// The array itself is never reset; it is zeroed by walking clr_ptr over it,
// so the storage and its read register can map onto SRAM.
module global_buffer_dp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    global_buffer_dp_if.slave bus
);
    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_ptr_reg, clr_ptr_next;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Write-port mux (sweep or user write)
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BE_W-1:0]     mem_be;

    logic busy;
    logic wr_oob, rd_oob;
    logic wr_req, rd_req, wr_acc, rd_hit, collide;

    // Read pipeline: raw array word plus the information needed to patch it
    logic [DATA_W-1:0]   mem_q_reg;
    logic                zero_q_reg;
    logic                byp_q_reg;
    logic [DATA_W-1:0]   byp_data_q_reg;
    logic [BE_W-1:0]     byp_be_q_reg;
    logic                rd_valid_reg;
    logic                addr_err_reg;
    logic [DATA_W-1:0]   rd_data;

    assign busy    = (state_reg == ST_CLEAR);
    assign wr_oob  = ({1'b0, bus.wr_addr} >= DEPTH_X);
    assign rd_oob  = ({1'b0, bus.rd_addr} >= DEPTH_X);
    assign wr_req  = bus.wr_en & ~busy;
    assign rd_req  = bus.rd_en & ~busy;
    assign wr_acc  = wr_req & ~wr_oob;
    assign rd_hit  = rd_req & ~rd_oob;
    assign collide = wr_acc & rd_hit & (bus.wr_addr == bus.rd_addr);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (clr_ptr_reg == LAST_ADDR) begin
                    state_next = ST_IDLE;
                end else begin
                    clr_ptr_next = clr_ptr_reg + ADDR_W'(1);
                end
            end
            default: begin
                if (bus.clr_req) begin
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end
            end
        endcase
    end

    // ---------------- storage ----------------
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.wr_addr;
        mem_wdata = bus.wr_data;
        mem_be    = bus.wr_be;
        if (busy) begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr_reg;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (wr_acc) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Plain registered array read; it sees the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (rd_hit) begin
            mem_q_reg <= mem[bus.rd_addr];
        end
    end

    // Side information is only captured on an accepted read, so rd_data
    // holds between reads. zero_q covers both reset and out-of-range reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q_reg     <= 1'b1;
            byp_q_reg      <= 1'b0;
            byp_data_q_reg <= '0;
            byp_be_q_reg   <= '0;
            rd_valid_reg   <= 1'b0;
            addr_err_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_req;
            addr_err_reg <= (wr_req & wr_oob) | (rd_req & rd_oob);
            if (rd_req) begin
                zero_q_reg     <= rd_oob;
                byp_q_reg      <= BYPASS && collide;
                byp_data_q_reg <= bus.wr_data;
                byp_be_q_reg   <= bus.wr_be;
            end
        end
    end

    // Output byte merge: bypassed bytes come from the captured write data.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_rd_byte
        always_comb begin
            rd_data[8*gi +: 8] = mem_q_reg[8*gi +: 8];
            if (zero_q_reg) begin
                rd_data[8*gi +: 8] = 8'h00;
            end else if (byp_q_reg && byp_be_q_reg[gi]) begin
                rd_data[8*gi +: 8] = byp_data_q_reg[8*gi +: 8];
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.addr_err = addr_err_reg;
endmodule

// File: tb/tb_global_buffer_dp.sv
// Bench for global_buffer_dp. Three instances share one stimulus stream:
//   dut_a : DEPTH=256, BYPASS=1
//   dut_b : DEPTH=256, BYPASS=0
//   dut_c : DEPTH=200, BYPASS=1 (addresses 200..255 out of range)
module tb_global_buffer_dp;
    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [7:0]  rd_addr;

    int total = 0;
    int bad   = 0;

    global_buffer_dp_if #(.DATA_W(32), .ADDR_W(8)) ifa ();
    global_buffer_dp_if #(.DATA_W(32), .ADDR_W(8)) ifb ();
    global_buffer_dp_if #(.DATA_W(32), .ADDR_W(8)) ifc ();

    assign ifa.clr_req = clr_req;  assign ifb.clr_req = clr_req;  assign ifc.clr_req = clr_req;
    assign ifa.wr_en   = wr_en;    assign ifb.wr_en   = wr_en;    assign ifc.wr_en   = wr_en;
    assign ifa.wr_addr = wr_addr;  assign ifb.wr_addr = wr_addr;  assign ifc.wr_addr = wr_addr;
    assign ifa.wr_data = wr_data;  assign ifb.wr_data = wr_data;  assign ifc.wr_data = wr_data;
    assign ifa.wr_be   = wr_be;    assign ifb.wr_be   = wr_be;    assign ifc.wr_be   = wr_be;
    assign ifa.rd_en   = rd_en;    assign ifb.rd_en   = rd_en;    assign ifc.rd_en   = rd_en;
    assign ifa.rd_addr = rd_addr;  assign ifb.rd_addr = rd_addr;  assign ifc.rd_addr = rd_addr;

    global_buffer_dp #(.DATA_W(32), .DEPTH(256), .BYPASS(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    global_buffer_dp #(.DATA_W(32), .DEPTH(256), .BYPASS(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    global_buffer_dp #(.DATA_W(32), .DEPTH(200), .BYPASS(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [7:0]  wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_be;
        logic        rd_en;
        logic [7:0]  rd_addr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_c;
        logic        exp_valid;
        logic        exp_err_c;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic we, logic [7:0] wa, logic [31:0] wd, logic [3:0] be,
                                logic re, logic [7:0] ra,
                                logic [31:0] ea, logic [31:0] eb, logic [31:0] ec,
                                logic ev, logic ee);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_be = be;
        v.rd_en = re; v.rd_addr = ra;
        v.exp_a = ea; v.exp_b = eb; v.exp_c = ec; v.exp_valid = ev; v.exp_err_c = ee;
        return v;
    endfunction

    // Advance one clock; outputs are sampled and inputs changed 1 time unit
    // after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    // Count busy cycles of dut_a and dut_c over a fixed window. With
    // 'poke' set, requests are driven during the sweep (writes at sweep
    // cycles 5..14 to already-cleared addresses, and a second clr_req).
    task automatic count_busy(input logic poke, output int na, output int nc, output int leak);
        na = 0; nc = 0; leak = 0;
        for (int k = 0; k < 300; k++) begin
            if (ifa.busy) na++;
            if (ifc.busy) nc++;
            if (ifa.busy && (ifa.rd_valid || ifa.addr_err)) leak++;
            if (ifc.busy && (ifc.rd_valid || ifc.addr_err)) leak++;
            if (poke) begin
                wr_en   = (k >= 5 && k < 15);
                rd_en   = (k >= 5 && k < 15);
                wr_addr = 8'(k % 4);
                rd_addr = 8'(k % 4);
                wr_data = 32'hBADBAD00 | 32'(k);
                wr_be   = 4'hF;
                clr_req = (k == 50);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int na, nc, leak;

        vecs[0]  = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd0,   32'h0,        32'h0,        32'h0,        1, 0);
        vecs[1]  = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd128, 32'h0,        32'h0,        32'h0,        1, 0);
        vecs[2]  = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd255, 32'h0,        32'h0,        32'h0,        1, 1);
        vecs[3]  = mk(1, 8'd5,   32'hAABBCCDD, 4'hF, 0, 8'd0,   32'h0,        32'h0,        32'h0,        0, 0);
        vecs[4]  = mk(1, 8'd5,   32'h11223344, 4'h5, 0, 8'd0,   32'h0,        32'h0,        32'h0,        0, 0);
        vecs[5]  = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd5,   32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1, 0);
        vecs[6]  = mk(1, 8'd9,   32'hDEADBEEF, 4'hF, 1, 8'd9,   32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1, 0);
        vecs[7]  = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd9,   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0);
        vecs[8]  = mk(1, 8'd10,  32'hCAFEF00D, 4'hF, 0, 8'd0,   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vecs[9]  = mk(1, 8'd210, 32'h12345678, 4'hF, 0, 8'd0,   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
        vecs[10] = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd210, 32'h12345678, 32'h12345678, 32'h0,        1, 1);
        vecs[11] = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd10,  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1, 0);
        vecs[12] = mk(1, 8'd20,  32'hFFFFFFFF, 4'h0, 1, 8'd20,  32'h0,        32'h0,        32'h0,        1, 0);
        vecs[13] = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd20,  32'h0,        32'h0,        32'h0,        1, 0);
        vecs[14] = mk(1, 8'd255, 32'h0F0F0F0F, 4'h8, 1, 8'd255, 32'h0F000000, 32'h0,        32'h0,        1, 1);
        vecs[15] = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd255, 32'h0F000000, 32'h0F000000, 32'h0,        1, 1);
        vecs[16] = mk(1, 8'd3,   32'h01020304, 4'h3, 1, 8'd2,   32'h0,        32'h0,        32'h0,        1, 0);
        vecs[17] = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd3,   32'h00000304, 32'h00000304, 32'h00000304, 1, 0);
        vecs[18] = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd199, 32'h0,        32'h0,        32'h0,        1, 0);
        vecs[19] = mk(0, 8'd0,   32'h0,        4'h0, 1, 8'd200, 32'h0,        32'h0,        32'h0,        1, 1);
        vecs[20] = mk(0, 8'd0,   32'h0,        4'h0, 0, 8'd0,   32'h0,        32'h0,        32'h0,        0, 0);

        // ---- reset state and initial sweep length ----
        rst_n = 1'b0;
        idle_inputs();
        step(); step(); step();
        check("reset_busy_a",     32'(ifa.busy),     32'd1);
        check("reset_rd_valid_a", 32'(ifa.rd_valid), 32'd0);
        check("reset_rd_data_a",  ifa.rd_data,       32'h0);
        check("reset_addr_err_a", 32'(ifa.addr_err), 32'd0);
        check("reset_busy_c",     32'(ifc.busy),     32'd1);
        rst_n = 1'b1;
        count_busy(1'b0, na, nc, leak);
        check("init_sweep_len_a", 32'(na), 32'd256);
        check("init_sweep_len_c", 32'(nc), 32'd200);
        $display("init sweep: busy_a=%0d busy_c=%0d", na, nc);

        // ---- table-driven vectors ----
        for (int i = 0; i < NVEC; i++) begin
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data; wr_be = vecs[i].wr_be;
            rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
            step();
            idle_inputs();
            $display("vec %0d: wr=%b@%0d rd=%b@%0d -> a=%08h b=%08h c=%08h valid=%b err_c=%b",
                     i, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].rd_en, vecs[i].rd_addr,
                     ifa.rd_data, ifb.rd_data, ifc.rd_data, ifa.rd_valid, ifc.addr_err);
            check($sformatf("v%0d_rd_data_a", i),  ifa.rd_data,        vecs[i].exp_a);
            check($sformatf("v%0d_rd_data_b", i),  ifb.rd_data,        vecs[i].exp_b);
            check($sformatf("v%0d_rd_data_c", i),  ifc.rd_data,        vecs[i].exp_c);
            check($sformatf("v%0d_rd_valid_a", i), 32'(ifa.rd_valid),  32'(vecs[i].exp_valid));
            check($sformatf("v%0d_rd_valid_c", i), 32'(ifc.rd_valid),  32'(vecs[i].exp_valid));
            check($sformatf("v%0d_addr_err_a", i), 32'(ifa.addr_err),  32'd0);
            check($sformatf("v%0d_addr_err_c", i), 32'(ifc.addr_err),  32'(vecs[i].exp_err_c));
        end

        // ---- clear sweep with requests held during busy ----
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 32'h11111111 * 32'(i + 1); wr_be = 4'hF;
            step();
            $display("fill: addr=%0d data=%08h", i, wr_data);
        end
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        count_busy(1'b1, na, nc, leak);
        $display("clear sweep: busy_a=%0d busy_c=%0d leaks=%0d", na, nc, leak);
        check("clr_sweep_len_a", 32'(na), 32'd256);
        check("clr_sweep_len_c", 32'(nc), 32'd200);
        check("clr_no_activity_while_busy", 32'(leak), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = 8'(i);
            step();
            idle_inputs();
            $display("post-clear read: addr=%0d a=%08h b=%08h c=%08h", i, ifa.rd_data, ifb.rd_data, ifc.rd_data);
            check($sformatf("clr_rd%0d_a", i), ifa.rd_data, 32'h0);
            check($sformatf("clr_rd%0d_b", i), ifb.rd_data, 32'h0);
            check($sformatf("clr_rd%0d_c", i), ifc.rd_data, 32'h0);
            check($sformatf("clr_rd%0d_valid_a", i), 32'(ifa.rd_valid), 32'd1);
        end

        // ---- reset in the middle of a sweep ----
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'h00000055; wr_be = 4'hF;
        step();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 8'd7;
        step();
        idle_inputs();
        check("pre_rst_rd_a", ifa.rd_data, 32'h00000055);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 100; k++) step();
        check("sweep_hold_rd_data_a", ifa.rd_data, 32'h00000055);
        check("sweep_busy_a", 32'(ifa.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_rd_data_a", ifa.rd_data, 32'h0);
        check("midrst_busy_a",    32'(ifa.busy), 32'd1);
        step();
        step();
        check("midrst_busy_after_2_a", 32'(ifa.busy), 32'd1);
        check("midrst_busy_after_2_c", 32'(ifc.busy), 32'd1);
        rst_n = 1'b1;
        count_busy(1'b0, na, nc, leak);
        $display("restart sweep: busy_a=%0d busy_c=%0d", na, nc);
        check("restart_sweep_len_a", 32'(na), 32'd256);
        check("restart_sweep_len_c", 32'(nc), 32'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
